// File: rtl/rv32i_lsu_hs.sv
// Handshaked RV32I load/store unit: lane steering, byte enables, load extension, bus timeout.
// Build option LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into two bus beats.
module rv32i_lsu_hs #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        func3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdat_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdat_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdat_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdat_i
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUS0, BUS1, RESP} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdat_q, rdat_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdat_q, mem_wdat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        off_q, off_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [3:0]        be_hi_q, be_hi_d;
    logic [31:0]       wdat_hi_q, wdat_hi_d;
    logic [31:0]       beat0_q, beat0_d;
    logic [63:0]       wd64;
    logic [63:0]       rd_pair;
`endif

    logic [1:0]  off_in;
    logic [3:0]  lane_m;
    logic [7:0]  mask8;
    logic        crosses;
    logic        illegal;
    logic [31:0] wd_lo;
    logic [31:0] gathered;
    logic [31:0] ext;
    logic        need_second;

    always_comb begin
        off_in = addr_i[1:0];
        case (func3_i[1:0])
            2'b00:   lane_m = 4'b0001;
            2'b01:   lane_m = 4'b0011;
            default: lane_m = 4'b1111;
        endcase
        mask8   = {4'b0000, lane_m} << off_in;
        crosses = |mask8[7:4];
        illegal = (func3_i[1:0] == 2'b11) || (we_i && func3_i[2]) || (crosses && !SPLIT_EN);

`ifdef LSU_MISALIGN_SPLIT_EN
        wd64        = {32'b0, wdat_i} << {off_in, 3'b000};
        wd_lo       = wd64[31:0];
        // Second beat supplies the upper bytes of the little-endian pair.
        rd_pair     = (state_q == BUS1) ? {mem_rdat_i, beat0_q} : {32'b0, mem_rdat_i};
        gathered    = 32'(rd_pair >> {off_q, 3'b000});
        need_second = (state_q == BUS0) && (be_hi_q != 4'b0000);
`else
        wd_lo       = wdat_i << {off_in, 3'b000};
        gathered    = mem_rdat_i >> {off_q, 3'b000};
        need_second = 1'b0;
`endif

        case (func3_q[1:0])
            2'b00:   ext = {{24{~func3_q[2] & gathered[7]}}, gathered[7:0]};
            2'b01:   ext = {{16{~func3_q[2] & gathered[15]}}, gathered[15:0]};
            default: ext = gathered;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdat_d     = rdat_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_be_d   = mem_be_q;
        mem_wdat_d = mem_wdat_q;
        cnt_d      = cnt_q;
        func3_d    = func3_q;
        off_d      = off_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        be_hi_d    = be_hi_q;
        wdat_hi_d  = wdat_hi_q;
        beat0_d    = beat0_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    busy_d  = 1'b1;
                    func3_d = func3_i;
                    off_d   = off_in;
                    if (illegal) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = BUS0;
                        mem_req_d  = 1'b1;
                        mem_we_d   = we_i;
                        mem_addr_d = {addr_i[ADDR_W-1:2], 2'b00};
                        mem_be_d   = mask8[3:0];
                        mem_wdat_d = wd_lo;
                        cnt_d      = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        be_hi_d    = mask8[7:4];
                        wdat_hi_d  = wd64[63:32];
`endif
                    end
                end
            end
            BUS0, BUS1: begin
                if (mem_ack_i) begin
                    if (need_second) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        state_d    = BUS1;
                        mem_addr_d = mem_addr_q + ADDR_W'(4);
                        mem_be_d   = be_hi_q;
                        mem_wdat_d = wdat_hi_q;
                        beat0_d    = mem_rdat_i;
                        cnt_d      = '0;
`endif
                    end else begin
                        state_d   = RESP;
                        mem_req_d = 1'b0;
                        done_d    = 1'b1;
                        if (!mem_we_q) begin
                            rdat_d = ext;
                        end
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    // Ack has priority over the abort in the final counted cycle.
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdat_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_be_q   <= '0;
            mem_wdat_q <= '0;
            cnt_q      <= '0;
            func3_q    <= '0;
            off_q      <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            be_hi_q    <= '0;
            wdat_hi_q  <= '0;
            beat0_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdat_q     <= rdat_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_be_q   <= mem_be_d;
            mem_wdat_q <= mem_wdat_d;
            cnt_q      <= cnt_d;
            func3_q    <= func3_d;
            off_q      <= off_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            be_hi_q    <= be_hi_d;
            wdat_hi_q  <= wdat_hi_d;
            beat0_q    <= beat0_d;
`endif
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign rdat_o     = rdat_q;
    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_be_o   = mem_be_q;
    assign mem_wdat_o = mem_wdat_q;

endmodule

// File: tb/tb_rv32i_lsu_hs.sv
// Directed testbench for rv32i_lsu_hs (TIMEOUT=4); split cases follow LSU_MISALIGN_SPLIT_EN.
module tb_rv32i_lsu_hs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i, we_i;
    logic [2:0]  func3_i;
    logic [31:0] addr_i, wdat_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdat_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdat_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdat_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdat;

    rv32i_lsu_hs #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .we_i(we_i), .func3_i(func3_i),
        .addr_i(addr_i), .wdat_i(wdat_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rdat_o(rdat_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdat_o(mem_wdat_o), .mem_ack_i(mem_ack_i), .mem_rdat_i(mem_rdat_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Presents a request for one edge; returns at the negedge of cycle 1.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_i = 1'b1; we_i = we; func3_i = f3; addr_i = a; wdat_i = d;
        @(negedge clk);
        req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = 0; we_i = 0; func3_i = 0; addr_i = 0; wdat_i = 0;
        mem_ack_i = 0; mem_rdat_i = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_o, done_o, err_o, mem_req_o, mem_we_o} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {busy_o, done_o, err_o, mem_req_o, mem_we_o});
        end
        checks++;
        if ({rdat_o, mem_addr_o, mem_be_o, mem_wdat_o} !== 100'b0) begin
            errors++; $display("FAIL reset_data rdat=%h addr=%h be=%b wdat=%h", rdat_o, mem_addr_o, mem_be_o, mem_wdat_o);
        end
        exp_rdat = 32'h0;
        $display("reset done");
    endtask

    task automatic test_lw();
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, busy_o} !== {1'b1, 1'b0, 32'h100, 4'b1111, 1'b1}) begin
            errors++; $display("FAIL lw_req req=%b we=%b addr=%h be=%b busy=%b", mem_req_o, mem_we_o, mem_addr_o, mem_be_o, busy_o);
        end
        mem_ack_i = 1'b1; mem_rdat_i = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack_i = 1'b0;
        exp_rdat = 32'hDEADBEEF;
        checks++;
        if ({done_o, err_o, mem_req_o, rdat_o} !== {3'b100, exp_rdat}) begin
            errors++; $display("FAIL lw_done done=%b err=%b req=%b rdat=%h want 1 0 0 %h", done_o, err_o, mem_req_o, rdat_o, exp_rdat);
        end
        @(negedge clk);
        checks++;
        if ({done_o, busy_o} !== 2'b00) begin
            errors++; $display("FAIL lw_pulse done=%b busy=%b want 00", done_o, busy_o);
        end
        $display("LW 0x100 rdat=%h", rdat_o);
    endtask

    task automatic test_lb_lbu();
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        checks++;
        if ({mem_addr_o, mem_be_o} !== {32'h100, 4'b1000}) begin
            errors++; $display("FAIL lb_lane addr=%h be=%b want 100 1000", mem_addr_o, mem_be_o);
        end
        mem_ack_i = 1'b1; mem_rdat_i = 32'h80123456;
        @(negedge clk);
        mem_ack_i = 1'b0;
        exp_rdat = 32'hFFFFFF80;
        checks++;
        if ({done_o, err_o, rdat_o} !== {2'b10, exp_rdat}) begin
            errors++; $display("FAIL lb_sext done=%b err=%b rdat=%h want %h", done_o, err_o, rdat_o, exp_rdat);
        end
        $display("LB 0x103 rdat=%h", rdat_o);
        issue(1'b0, 3'b100, 32'h103, 32'h0);
        mem_ack_i = 1'b1; mem_rdat_i = 32'h80123456;
        @(negedge clk);
        mem_ack_i = 1'b0;
        exp_rdat = 32'h00000080;
        checks++;
        if ({done_o, rdat_o} !== {1'b1, exp_rdat}) begin
            errors++; $display("FAIL lbu_zext done=%b rdat=%h want %h", done_o, rdat_o, exp_rdat);
        end
        $display("LBU 0x103 rdat=%h", rdat_o);
    endtask

    task automatic test_sh_wait();
        issue(1'b1, 3'b001, 32'h201, 32'h00001234);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdat_o[23:8], done_o} !==
                {1'b1, 1'b1, 32'h200, 4'b0110, 16'h1234, 1'b0}) begin
                errors++; $display("FAIL sh_hold c=%0d req=%b we=%b addr=%h be=%b wdat=%h done=%b",
                                   c, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdat_o, done_o);
            end
            if (c == 4) mem_ack_i = 1'b1;
            @(negedge clk);
        end
        mem_ack_i = 1'b0;
        checks++;
        if ({done_o, err_o, mem_req_o, rdat_o} !== {3'b100, exp_rdat}) begin
            errors++; $display("FAIL sh_done done=%b err=%b req=%b rdat=%h want 1 0 0 %h", done_o, err_o, mem_req_o, rdat_o, exp_rdat);
        end
        $display("SH 0x201 3 waits done=%b", done_o);
    endtask

    task automatic test_misalign();
        issue(1'b0, 3'b010, 32'h302, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++;
        if ({mem_req_o, mem_addr_o, mem_be_o} !== {1'b1, 32'h300, 4'b1100}) begin
            errors++; $display("FAIL split_b0 req=%b addr=%h be=%b", mem_req_o, mem_addr_o, mem_be_o);
        end
        mem_ack_i = 1'b1; mem_rdat_i = 32'h44332211;
        @(negedge clk);
        mem_rdat_i = 32'h88776655;
        checks++;
        if ({mem_req_o, mem_addr_o, mem_be_o, done_o} !== {1'b1, 32'h304, 4'b0011, 1'b0}) begin
            errors++; $display("FAIL split_b1 req=%b addr=%h be=%b done=%b", mem_req_o, mem_addr_o, mem_be_o, done_o);
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
        exp_rdat = 32'h66554433;
        checks++;
        if ({done_o, err_o, rdat_o} !== {2'b10, exp_rdat}) begin
            errors++; $display("FAIL split_rd done=%b err=%b rdat=%h want %h", done_o, err_o, rdat_o, exp_rdat);
        end
        $display("LW 0x302 split rdat=%h", rdat_o);
        issue(1'b1, 3'b010, 32'h302, 32'hAABBCCDD);
        checks++;
        if ({mem_addr_o, mem_be_o, mem_wdat_o[31:16]} !== {32'h300, 4'b1100, 16'hCCDD}) begin
            errors++; $display("FAIL sw_split_b0 addr=%h be=%b wdat=%h", mem_addr_o, mem_be_o, mem_wdat_o);
        end
        mem_ack_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_addr_o, mem_be_o, mem_wdat_o[15:0]} !== {32'h304, 4'b0011, 16'hAABB}) begin
            errors++; $display("FAIL sw_split_b1 addr=%h be=%b wdat=%h", mem_addr_o, mem_be_o, mem_wdat_o);
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
        checks++;
        if ({done_o, err_o, rdat_o} !== {2'b10, exp_rdat}) begin
            errors++; $display("FAIL sw_split_done done=%b err=%b rdat=%h", done_o, err_o, rdat_o);
        end
        $display("SW 0x302 split done=%b", done_o);
`else
        checks++;
        if ({done_o, err_o, mem_req_o, rdat_o} !== {3'b110, exp_rdat}) begin
            errors++; $display("FAIL nosplit_err done=%b err=%b req=%b rdat=%h", done_o, err_o, mem_req_o, rdat_o);
        end
        begin
            logic saw_req;
            saw_req = mem_req_o;
            repeat (3) begin
                @(negedge clk);
                saw_req = saw_req | mem_req_o;
            end
            checks++;
            if (saw_req !== 1'b0) begin
                errors++; $display("FAIL nosplit_noreq saw mem_req=%b want 0", saw_req);
            end
        end
        $display("LW 0x302 no split err=1");
`endif
    endtask

    task automatic test_timeout();
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({mem_req_o, done_o} !== 2'b10) begin
                errors++; $display("FAIL to_hold c=%0d req=%b done=%b want 10", c, mem_req_o, done_o);
            end
            @(negedge clk);
        end
        checks++;
        if ({mem_req_o, done_o, err_o, rdat_o} !== {3'b011, exp_rdat}) begin
            errors++; $display("FAIL to_abort req=%b done=%b err=%b rdat=%h want 0 1 1 %h", mem_req_o, done_o, err_o, rdat_o, exp_rdat);
        end
        $display("LW 0x400 timeout err=%b", err_o);
    endtask

    task automatic test_illegal_reset();
        issue(1'b0, 3'b011, 32'h500, 32'h0);
        checks++;
        if ({done_o, err_o, mem_req_o} !== 3'b110) begin
            errors++; $display("FAIL ill_f3 done=%b err=%b req=%b want 110", done_o, err_o, mem_req_o);
        end
        issue(1'b1, 3'b100, 32'h500, 32'h0);
        checks++;
        if ({done_o, err_o, mem_req_o} !== 3'b110) begin
            errors++; $display("FAIL ill_store done=%b err=%b req=%b want 110", done_o, err_o, mem_req_o);
        end
        issue(1'b0, 3'b010, 32'h600, 32'h0);
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++; $display("FAIL rst_pre req=%b want 1", mem_req_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, busy_o} !== 2'b00) begin
            errors++; $display("FAIL rst_async req=%b busy=%b want 00", mem_req_o, busy_o);
        end
        begin
            logic saw_done;
            saw_done = 1'b0;
            repeat (3) begin
                @(negedge clk);
                saw_done = saw_done | done_o;
            end
            rst_n = 1'b1;
            repeat (2) begin
                @(negedge clk);
                saw_done = saw_done | done_o;
            end
            exp_rdat = 32'h0;
            checks++;
            if ({saw_done, busy_o, mem_req_o, rdat_o} !== {3'b000, exp_rdat}) begin
                errors++; $display("FAIL rst_after done_seen=%b busy=%b req=%b rdat=%h", saw_done, busy_o, mem_req_o, rdat_o);
            end
        end
        $display("illegal + mid-access reset handled");
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        mem_ack_i = 1'b1; mem_rdat_i = 32'h11111111;
        @(negedge clk);
        mem_ack_i = 1'b0;
        issue(1'b0, 3'b001, 32'h106, 32'h0);
        checks++;
        if ({mem_addr_o, mem_be_o} !== {32'h104, 4'b1100}) begin
            errors++; $display("FAIL b2b_lh_lane addr=%h be=%b", mem_addr_o, mem_be_o);
        end
        mem_ack_i = 1'b1; mem_rdat_i = 32'h9ABC2222;
        @(negedge clk);
        mem_ack_i = 1'b0;
        exp_rdat = 32'hFFFF9ABC;
        checks++;
        if ({done_o, rdat_o} !== {1'b1, exp_rdat}) begin
            errors++; $display("FAIL b2b_lh done=%b rdat=%h want %h", done_o, rdat_o, exp_rdat);
        end
        issue(1'b1, 3'b000, 32'h102, 32'h000000A5);
        checks++;
        if ({mem_we_o, mem_be_o, mem_wdat_o[23:16]} !== {1'b1, 4'b0100, 8'hA5}) begin
            errors++; $display("FAIL sb_lane we=%b be=%b wdat=%h", mem_we_o, mem_be_o, mem_wdat_o);
        end
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        checks++;
        if ({done_o, err_o, rdat_o} !== {2'b10, exp_rdat}) begin
            errors++; $display("FAIL sb_done done=%b err=%b rdat=%h want %h", done_o, err_o, rdat_o, exp_rdat);
        end
        $display("back-to-back LW/LH/SB rdat=%h", rdat_o);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_wait();
        test_misalign();
        test_timeout();
        test_illegal_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
